// File: rtl/demux1to8_16bit_reg_pkg.sv
// rtl/demux1to8_16bit_reg_pkg.sv - shared constants for the 1-to-8 registered demultiplexer
//
// Purpose: lane count, select width and default data width shared by
// the top level, the lane register and the bench.
package demux1to8_16bit_reg_pkg;

  localparam int LANES          = 8;
  localparam int SEL_W          = 3;
  localparam int DEFAULT_DATA_W = 16;
  localparam int COUNT_W        = 16;

endpackage

// File: rtl/demux_lane.sv
// rtl/demux_lane.sv - single output lane register with valid/ready handshake
//
// Purpose: holds one word for one consumer until it is taken.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - write load_data this cycle (already qualified by accept)
//   load_data   - word to store
//   ready       - consumer takes the held word this cycle
//   data        - held word, kept after delivery
//   valid       - data holds an undelivered word
module demux_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // A load in the same cycle as a delivery takes priority, so valid stays
  // high and the lane can stream one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to8_16bit_reg.sv
// rtl/demux1to8_16bit_reg.sv - 1-to-8 demultiplexer with registered, handshaked output lanes
//
// Purpose: routes each accepted input word to the lane named by in_select.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_data/in_select       - word and destination lane
//   in_valid/in_ready       - input handshake
//   out_data0..out_data7    - registered lane data
//   out_valid/out_ready     - per-lane output handshake, bit k = lane k
//   xfer_count              - accepted words, modulo 2^16
module demux1to8_16bit_reg
  import demux1to8_16bit_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data0,
  output logic [DATA_W-1:0]  out_data1,
  output logic [DATA_W-1:0]  out_data2,
  output logic [DATA_W-1:0]  out_data3,
  output logic [DATA_W-1:0]  out_data4,
  output logic [DATA_W-1:0]  out_data5,
  output logic [DATA_W-1:0]  out_data6,
  output logic [DATA_W-1:0]  out_data7,
  output logic [LANES-1:0]   out_valid,
  input  logic [LANES-1:0]   out_ready,
  output logic [COUNT_W-1:0] xfer_count
);

  logic              accept;
  logic [LANES-1:0]  load;
  logic [DATA_W-1:0] lane_data [LANES];

  // Selected lane can take a word if empty or being drained this cycle.
  // Gated by rst_n so the block reports not-ready while held in reset.
  assign in_ready = rst_n & (~out_valid[in_select] | out_ready[in_select]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[in_select] = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .data      (lane_data[k]),
      .valid     (out_valid[k])
    );
  end

  assign out_data0 = lane_data[0];
  assign out_data1 = lane_data[1];
  assign out_data2 = lane_data[2];
  assign out_data3 = lane_data[3];
  assign out_data4 = lane_data[4];
  assign out_data5 = lane_data[5];
  assign out_data6 = lane_data[6];
  assign out_data7 = lane_data[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux1to8_16bit_reg.sv
// tb/tb_demux1to8_16bit_reg.sv - directed self-checking bench for demux1to8_16bit_reg
module tb_demux1to8_16bit_reg;
  import demux1to8_16bit_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data0, out_data1, out_data2, out_data3;
  logic [15:0] out_data4, out_data5, out_data6, out_data7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] xfer_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux1to8_16bit_reg #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_data4  (out_data4),
    .out_data5  (out_data5),
    .out_data6  (out_data6),
    .out_data7  (out_data7),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  function automatic logic [15:0] lane(input int k);
    case (k)
      0: return out_data0;
      1: return out_data1;
      2: return out_data2;
      3: return out_data3;
      4: return out_data4;
      5: return out_data5;
      6: return out_data6;
      default: return out_data7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_select = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    #1;
    check("reset out_valid", out_valid, 8'h00);
    check("reset xfer_count", xfer_count, 16'h0000);
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_data3", out_data3, 16'h0000);
    step();
    step();

    // First accept on the first edge after release.
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_select = 3'd3;
    in_data   = 16'hA5A5;
    #1;
    check("first in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("first out_valid", out_valid, 8'h08);
    check("first out_data3", out_data3, 16'hA5A5);
    check("first xfer_count", xfer_count, 16'h0001);

    // Deliver lane 3; data is retained afterwards.
    out_ready = 8'h08;
    step();
    out_ready = 8'h00;
    check("lane3 drained valid", out_valid, 8'h00);
    check("lane3 data kept", out_data3, 16'hA5A5);

    // Lane 5 full and stalled, then released.
    in_valid = 1'b1; in_select = 3'd5; in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    #1;
    check("lane5 stall in_ready", in_ready, 1'b0);
    step();
    check("lane5 stall data held", out_data5, 16'h1111);
    check("lane5 stall xfer_count", xfer_count, 16'h0002);
    out_ready = 8'h20;
    #1;
    check("lane5 release in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = 8'h00;
    check("lane5 new data", out_data5, 16'h2222);
    check("lane5 still valid", out_valid, 8'h20);
    check("lane5 xfer_count", xfer_count, 16'h0003);
    out_ready = 8'h20;
    step();
    out_ready = 8'h00;
    check("lane5 drained", out_valid, 8'h00);

    // Back-to-back stream on lane 2 with consumer always ready.
    out_ready = 8'h04;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_select = 3'd2; in_data = 16'(i);
      step();
      check("stream lane2 data", out_data2, 16'(i));
      check("stream lane2 valid", out_valid, 8'h04);
    end
    in_valid = 1'b0;
    step();
    out_ready = 8'h00;
    check("stream drained", out_valid, 8'h00);
    check("stream xfer_count", xfer_count, 16'd11);

    // Fill every lane, consumers stalled.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_select = 3'(k); in_data = 16'hB000 + 16'(k);
      #1;
      check("fill in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    check("fill out_valid", out_valid, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      check("fill out_data", lane(k), 16'hB000 + 16'(k));
    end
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_select = 3'(k);
      #1;
      check("full in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; in_select = 3'd0; in_data = 16'hDEAD;
    step();
    check("idle no load data0", out_data0, 16'hB000);
    check("full xfer_count", xfer_count, 16'd19);

    // Leave lanes 2..5 full, then pulse reset between edges.
    out_ready = 8'hC3;
    step();
    out_ready = 8'h00;
    check("pre-reset out_valid", out_valid, 8'h3C);
    in_valid = 1'b1; in_select = 3'd2; in_data = 16'h7777;
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 8'h00);
    check("async reset in_ready", in_ready, 1'b0);
    check("async reset xfer_count", xfer_count, 16'h0000);
    check("async reset out_data2", out_data2, 16'h0000);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    check("post reset no delivery", out_valid, 8'h00);

    // Counter wrap after 65536 accepts on a streaming lane.
    out_ready = 8'h01;
    in_valid = 1'b1; in_select = 3'd0; in_data = 16'h5555;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap preload", xfer_count, 16'hFFFF);
    step();
    check("wrap to zero", xfer_count, 16'h0000);
    in_valid = 1'b0;
    out_ready = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1to8_16bit_reg.md
DEMUX1TO8_16BIT_REG -- requirements
Module: demux1to8_16bit_reg

Interface
REQ-001 Parameter: DATA_W, 16, width of the data path and of every output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_data  input  DATA_W  word to be delivered.
REQ-005 Port: in_select  input  3  destination lane index, 0..7.
REQ-006 Port: in_valid  input  1  producer has a word on in_data/in_select.
REQ-007 Port: in_ready  output  1  block accepts the word this cycle.
REQ-008 Port: out_data0 .. out_data7  output  DATA_W each  registered lane data.
REQ-009 Port: out_valid  output  8  bit k set = out_data<k> holds an undelivered word.
REQ-010 Port: out_ready  input  8  bit k set = consumer k takes its word this cycle.
REQ-011 Port: xfer_count  output  16  number of accepted input words, modulo 2^16.

Function
REQ-012 Accept occurs in a cycle when in_valid and in_ready are both 1.
REQ-013 in_ready SHALL equal (not out_valid[in_select]) or out_ready[in_select]; combinational; 0 while rst_n is low.
REQ-014 On accept, out_data<in_select> SHALL load in_data and out_valid[in_select] SHALL be 1 at the next edge; latency exactly 1 cycle.
REQ-015 Lane k delivers in a cycle where out_valid[k] and out_ready[k] are both 1; out_valid[k] SHALL clear at the next edge unless lane k is loaded in that same cycle.
REQ-016 Simultaneous deliver and load on the same lane: load wins; out_valid[k] stays 1, new data appears; sustained throughput 1 word/cycle per lane.
REQ-017 While out_valid[k]=1 and out_ready[k]=0, out_data<k> SHALL be held stable.
REQ-018 Lanes not selected by an accept SHALL retain data and valid, subject only to their own delivery.
REQ-019 When in_valid=1 and in_ready=0 (selected lane full, consumer stalled), no state changes for the input; producer must hold in_data/in_select.
REQ-020 out_data<k> SHALL keep its last value after delivery (not cleared).
REQ-021 xfer_count SHALL increment by 1 on each accept and wrap 16'hFFFF -> 16'h0000.
REQ-022 in_valid=0 SHALL cause no lane load regardless of in_select.

Reset
REQ-023 rst_n low SHALL asynchronously force out_valid=8'h00, all out_data<k>=0, xfer_count=0.
REQ-024 Reset asserted mid-operation SHALL discard all pending lane words; no delivery is reported after reset.
REQ-025 First accept is possible in the first rising edge after rst_n deasserts.

Structure
REQ-026 Shared package SHALL hold the lane count constant (8), select width constant (3) and default data width (16).
REQ-027 One sub-module demux_lane SHALL implement a single lane register (load, data, valid, ready, hold); instantiated 8 times.
REQ-028 Top level SHALL contain only the select decode, in_ready generation and xfer_count.

Verification
REQ-029 Reset release, in_valid=1, in_select=3, in_data=16'hA5A5 -> next cycle out_valid=8'h08, out_data3=16'hA5A5, xfer_count=1.
REQ-030 Lane 5 full, out_ready[5]=0, new word to lane 5 -> in_ready=0, out_data5 unchanged; raise out_ready[5] -> accept same cycle, new data next cycle.
REQ-031 Back-to-back words 16'h0001..16'h0008 to lane 2, out_ready[2]=1 constant -> one delivery per cycle, in order, out_valid[2] continuously 1.
REQ-032 Words to lanes 0..7 in consecutive cycles, all out_ready=0 -> out_valid=8'hFF, each out_data<k> correct; further input to any lane -> in_ready=0.
REQ-033 Preload xfer_count to 16'hFFFF via 65535 accepts, one more accept -> xfer_count=16'h0000.
REQ-034 rst_n pulsed low between edges with out_valid=8'h3C -> out_valid=0 and in_ready=0 immediately, no clock edge required.
